keypad_box_scanner: RTL and testbench
=====================================

// Module: keypad_box_scanner
// PURPOSE
//  Scans the 3x3 player keypad and produces the debounced, level-valued box[8:0]
//  occupancy vector that the game controller consumes for fire/gold collision.
//  Drives the column lines one at a time and samples the row lines.
//  Synchronises the asynchronous rows and debounces each key independently.
//  Flags every change of box with a one-cycle pulse.
// PARAMETERS
//  SCAN_DIV        50000  clk cycles each column is held active (must be >= 3)
//  DEBOUNCE_SCANS  8      consecutive disagreeing samples needed to flip a key (>= 1)
// PORTS
//  clk          in   1  system clock; the single clock of this block
//  rst          in   1  synchronous, active-high reset
//  row_n        in   3  keypad rows, active low, asynchronous to clk
//  col_n        out  3  keypad column drive, one-hot low
//  box          out  9  debounced key state; key (row r, col c) -> box[3*r+c]
//  box_changed  out  1  one-cycle pulse on the edge where any box bit updates
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   col_n=3'b110; dwell counter=0; all debounce counters=0; box=0;
//   box_changed=0; both synchroniser stages=3'b111.
//  Column scan FSM, states COL0 -> COL1 -> COL2 -> COL0:
//   col_n = 110 / 101 / 011.
//   Each state holds for SCAN_DIV cycles, counted by dwell 0..SCAN_DIV-1.
//   The state advances on the edge where dwell==SCAN_DIV-1, and dwell returns to 0.
//  Row synchroniser: a 2-FF chain on row_n. The second stage (rs) is the only row value used.
//  Sampling:
//   Sample on the edge where dwell==SCAN_DIV-1 in column c.
//   For each r, the key (r,c) sample is s = ~rs[r] (1 = pressed).
//   SCAN_DIV>=3 guarantees that rs reflects the currently driven column.
//   Only the three keys of column c are evaluated at that edge. All other keys hold state.
//  Per-key debounce (one counter per key, width $clog2(DEBOUNCE_SCANS+1)):
//   s == box[i]: cnt_i <= 0.
//   s != box[i] and cnt_i == DEBOUNCE_SCANS-1: box[i] <= s; cnt_i <= 0.
//   s != box[i] otherwise: cnt_i <= cnt_i + 1.
//   The counter never wraps. It is cleared on flip or on any agreeing sample.
//  box_changed: registered high for exactly the cycle after an edge that flips one or
//   more bits. Several bits flipping on one edge give a single pulse. Low otherwise.
//  Latency:
//   A held key is sampled once per 3*SCAN_DIV cycles.
//   Worst case from stable press/release to box update is
//   (DEBOUNCE_SCANS+1)*3*SCAN_DIV + 2 cycles.
//  Simultaneous keys: all keys are independent. Any combination, including all 9, is
//   reported. Ghosting is not suppressed; the controller tolerates multi-bit box.
//  Reset mid-debounce or mid-scan: state is discarded, the scan restarts at COL0 dwell 0,
//   and box goes to 0 on the next cycle even if keys are held. Held keys re-qualify
//   through the full debounce.
//  box is registered and glitch-free. It changes only on sample edges.
// TESTING  (bench overrides SCAN_DIV=4, DEBOUNCE_SCANS=3; cycle 0 = first edge with rst=0)
//  1 Reset: rst=1 for 2 cycles with row_n=000 -> box=0, box_changed=0, col_n=110;
//    col_n sequence 110x4, 101x4, 011x4, then repeats.
//  2 Single press: hold key (1,1) from reset (row_n[1]=0 while col_n=101) -> samples at
//    edges 7, 19, 31; box=9'h010 from cycle 32; box_changed=1 only in cycle 32.
//  3 Bounce reject: after test 2, release key (1,1) for only the edge-43 and edge-55
//    samples, then press again -> box stays 9'h010 and box_changed never pulses.
//  4 Release: release key (1,1) permanently before edge 43 -> box=0 from cycle 68 (after
//    edges 43/55/67), one box_changed pulse.
//  5 Multi-key: hold keys (0,0) and (2,2) together from reset -> box[0] rises cycle 28,
//    box[8] rises cycle 36; final box=9'h101; two separate box_changed pulses.
//  6 Reset mid-debounce: hold key (0,2) and assert rst at cycle 30 (after 2 samples) ->
//    box stays 0; after release of rst the key needs 3 fresh samples before box[2]=1.

Source files
------------

// File: rtl/keypad_box_scanner.sv
// Keypad box scanner: drives the 3x3 keypad columns one at a time, synchronises the
// asynchronous rows, debounces every key independently and reports the result as a
// registered, level-valued box[8:0] plus a one-cycle box_changed pulse.
module keypad_box_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] row_n,
  output logic [2:0] col_n,
  output logic [8:0] box,
  output logic       box_changed
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]   CntLast   = CntW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {StCol0, StCol1, StCol2} col_state_e;

  col_state_e        state_q, state_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [2:0]        row_meta_q;
  logic [2:0]        rs_q;
  logic [8:0]        box_q, box_d;
  logic              changed_q, changed_d;
  logic              sample_edge;
  logic [2:0]        col_sel;
  logic [8:0]        flip_vec;

  // Column scan: dwell counter and column sequencing.
  always_comb begin
    state_d     = state_q;
    sample_edge = (dwell_q == DwellLast);
    dwell_d     = sample_edge ? '0 : dwell_q + DwellW'(1);
    col_n       = 3'b110;
    unique case (state_q)
      StCol0: begin
        col_n = 3'b110;
        if (sample_edge) state_d = StCol1;
      end
      StCol1: begin
        col_n = 3'b101;
        if (sample_edge) state_d = StCol2;
      end
      StCol2: begin
        col_n = 3'b011;
        if (sample_edge) state_d = StCol0;
      end
      default: begin
        col_n   = 3'b110;
        state_d = StCol0;
      end
    endcase
  end

  // One-hot (active high) view of the driven column.
  assign col_sel = ~col_n;

  // Per-key debounce; only keys in the driven column are evaluated on the sample edge.
  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            pressed;
      logic            toggle;

      assign pressed = ~rs_q[r];

      // Next counter value and flip decision for this key.
      always_comb begin
        cnt_d  = cnt_q;
        toggle = 1'b0;
        if (sample_edge && col_sel[c]) begin
          if (pressed == box_q[3*r+c]) begin
            cnt_d = '0;
          end else if (cnt_q == CntLast) begin
            cnt_d  = '0;
            toggle = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      // Debounce counter register.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign flip_vec[3*r+c] = toggle;
    end
  end

  // A flip always moves the bit to the sampled value, so XOR is sufficient.
  always_comb begin
    box_d     = box_q ^ flip_vec;
    changed_d = |flip_vec;
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCol0;
      dwell_q    <= '0;
      row_meta_q <= 3'b111;
      rs_q       <= 3'b111;
      box_q      <= '0;
      changed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      row_meta_q <= row_n;
      rs_q       <= row_meta_q;
      box_q      <= box_d;
      changed_q  <= changed_d;
    end
  end

  assign box         = box_q;
  assign box_changed = changed_q;

endmodule

// File: tb/tb_keypad_box_scanner.sv
// Bench for keypad_box_scanner: a keypad model closes row/column contacts, and a
// behavioural model (edge counting plus per-key disagreement counts) predicts
// box, box_changed and col_n after every clock edge.
module tb_keypad_box_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] row_n;
  logic [2:0] col_n;
  logic [8:0] box;
  logic       box_changed;

  logic [8:0] keys;       // key (r,c) held down -> keys[3*r+c]
  logic       force_low;  // pull every row low regardless of keys

  // Reference model state.
  int         n;          // non-reset edges since the last reset edge
  logic [8:0] m_box;
  int         m_cnt [9];
  logic       m_chg;
  int         pulses;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 3'b111;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[3*r+c] && (col_n[c] === 1'b0)) row_n[r] = 1'b0;
      end
    end
    if (force_low) row_n = 3'b000;
  end

  keypad_box_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .box        (box),
    .box_changed(box_changed)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (time=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  // Advance the model across one clock edge. Each column owns SD edges; the last one samples.
  task automatic model_edge();
    int col;
    int idx;
    if (rst) begin
      n     = 0;
      m_box = '0;
      m_chg = 1'b0;
      for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    end else begin
      m_chg = 1'b0;
      if (((n + 1) % SD) == 0) begin
        col = ((n + 1) / SD - 1) % 3;
        for (int r = 0; r < 3; r++) begin
          idx = 3 * r + col;
          if (keys[idx] == m_box[idx]) begin
            m_cnt[idx] = 0;
          end else if (m_cnt[idx] + 1 >= DS) begin
            m_box[idx] = keys[idx];
            m_cnt[idx] = 0;
            m_chg      = 1'b1;
          end else begin
            m_cnt[idx] = m_cnt[idx] + 1;
          end
        end
      end
      n++;
    end
  endtask

  task automatic tick();
    logic [2:0] exp_col;
    @(posedge clk);
    model_edge();
    #1;
    exp_col = ~(3'(1) << ((n / SD) % 3));
    check_eq("box", 32'(box), 32'(m_box));
    check_eq("box_changed", 32'(box_changed), 32'(m_chg));
    check_eq("col_n", 32'(col_n), 32'(exp_col));
    if (box_changed === 1'b1) pulses++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  initial begin
    rst       = 1'b1;
    keys      = '0;
    force_low = 1'b1;
    n         = 0;
    m_box     = '0;
    m_chg     = 1'b0;
    pulses    = 0;
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;

    // Reset with all rows low, then free-running column sequence.
    do_reset(2);
    check_eq("t1_box_rst", 32'(box), 32'h0);
    check_eq("t1_chg_rst", 32'(box_changed), 32'h0);
    check_eq("t1_col_rst", 32'(col_n), 32'h6);
    force_low = 1'b0;
    run_to(4);
    check_eq("t1_col_4", 32'(col_n), 32'h5);
    run_to(8);
    check_eq("t1_col_8", 32'(col_n), 32'h3);
    run_to(12);
    check_eq("t1_col_12", 32'(col_n), 32'h6);

    // Single press of (1,1), then a two-sample bounce that must be rejected.
    keys = 9'h010;
    do_reset(2);
    run_to(31);
    check_eq("t2_box31", 32'(box), 32'h0);
    run_to(32);
    check_eq("t2_box32", 32'(box), 32'h010);
    check_eq("t2_pulse32", 32'(box_changed), 32'h1);
    run_to(33);
    check_eq("t2_pulse33", 32'(box_changed), 32'h0);
    pulses = 0;
    run_to(40);
    keys = 9'h000;
    run_to(56);
    keys = 9'h010;
    run_to(80);
    check_eq("t3_box", 32'(box), 32'h010);
    check_eq("t3_no_pulse", 32'(pulses), 32'h0);

    // Permanent release of (1,1).
    keys = 9'h010;
    do_reset(2);
    run_to(40);
    keys   = 9'h000;
    pulses = 0;
    run_to(67);
    check_eq("t4_box67", 32'(box), 32'h010);
    run_to(68);
    check_eq("t4_box68", 32'(box), 32'h0);
    run_to(80);
    check_eq("t4_pulses", 32'(pulses), 32'h1);

    // Keys (0,0) and (2,2) held together.
    keys = 9'h101;
    do_reset(2);
    pulses = 0;
    run_to(27);
    check_eq("t5_box27", 32'(box), 32'h0);
    run_to(28);
    check_eq("t5_box28", 32'(box), 32'h001);
    run_to(35);
    check_eq("t5_box35", 32'(box), 32'h001);
    run_to(36);
    check_eq("t5_box36", 32'(box), 32'h101);
    run_to(60);
    check_eq("t5_pulses", 32'(pulses), 32'h2);

    // Reset in the middle of debouncing (0,2).
    keys = 9'h004;
    do_reset(2);
    run_to(30);
    do_reset(2);
    check_eq("t6_box_rst", 32'(box), 32'h0);
    run_to(35);
    check_eq("t6_box35", 32'(box), 32'h0);
    run_to(36);
    check_eq("t6_box36", 32'(box), 32'h004);

    // Randomised episodes: keys change just after sample edges, occasional resets.
    for (int ep = 0; ep < 20; ep++) begin
      keys = 9'($urandom);
      do_reset(int'($urandom_range(1, 3)));
      for (int cyc = 0; cyc < 300; cyc++) begin
        if ($urandom_range(0, 249) == 0) begin
          keys = 9'($urandom);
          do_reset(int'($urandom_range(1, 2)));
        end else begin
          if (n > 0 && (n % SD) == 0 && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) keys = keys ^ (9'(1) << $urandom_range(0, 8));
            else keys = 9'($urandom);
          end
          tick();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
